seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 101 ++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; registered results are held until the next result edge.
module seq_divider #(
   parameter int unsigned W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic [2*W-1:0] quotient,
   output logic [W-1:0]   remainder,
   output logic           busy,
   output logic           done,
   output logic           div_by_zero
);

   localparam int unsigned CntW = $clog2(2 * W) + 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e          state_q;
   logic [2*W-1:0]  dvd_q;
   logic [2*W-1:0]  quo_q;
   logic [W-1:0]    dsr_q;
   logic [W-1:0]    rem_q;
   logic [CntW-1:0] cnt_q;

   logic [W:0]      p;
   logic            ge;
   logic [W-1:0]    rem_next;
   logic [2*W-1:0]  quo_next;
   logic            last;

   // After a subtraction the result is below the divisor, so W bits of P are enough.
   always_comb begin
      p        = {rem_q, dvd_q[2*W-1]};
      ge       = (p >= {1'b0, dsr_q});
      rem_next = ge ? (p[W-1:0] - dsr_q) : p[W-1:0];
      quo_next = {quo_q[2*W-2:0], ge};
      last     = (cnt_q == CntW'(2 * W - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         dvd_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               done <= 1'b0;
               if (start) begin
                  dvd_q       <= dividend;
                  dsr_q       <= divisor;
                  rem_q       <= '0;
                  quo_q       <= '0;
                  cnt_q       <= '0;
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  state_q     <= StBusy;
               end else begin
                  state_q <= StIdle;
               end
            end
            StBusy: begin
               if (dsr_q == '0) begin
                  quotient    <= '1;
                  remainder   <= '0;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state_q     <= StDone;
               end else begin
                  rem_q <= rem_next;
                  dvd_q <= {dvd_q[2*W-2:0], 1'b0};
                  quo_q <= quo_next;
                  cnt_q <= cnt_q + CntW'(1);
                  if (last) begin
                     quotient  <= quo_next;
                     remainder <= rem_next;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_q   <= StDone;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (W=4): handshake timing, boundaries, abort, back-to-back, sweep.
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int tests = 0;
   int fails = 0;

   seq_divider #(.W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Returns the number of edges after the accepting edge until done is seen (99 if never).
   task automatic wait_done(output int lat);
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_div(input string tag, input logic [7:0] dd, input logic [3:0] ds,
                          input logic [7:0] eq, input logic [3:0] er, input logic edz,
                          input int elat);
      int lat;
      start    = 1'b1;
      dividend = dd;
      divisor  = ds;
      tick();
      start = 1'b0;
      check({tag, " busy after accept"}, busy, 1);
      check({tag, " dz cleared on accept"}, div_by_zero, 0);
      wait_done(lat);
      check({tag, " latency"}, lat, elat);
      check({tag, " busy at done"}, busy, 0);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, div_by_zero, edz);
   endtask

   initial begin
      int lat;
      int pulses;
      logic [7:0] q_at_done;
      logic [3:0] r_at_done;

      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      tick(); tick();
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset dz", div_by_zero, 0);
      rst_n = 1'b1;
      tick();

      run_div("200/7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
      tick();
      check("200/7 done one cycle", done, 0);
      check("200/7 result held", quotient, 28);

      run_div("255/1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
      run_div("0/15", 8'd0, 4'd15, 8'd0, 4'd0, 1'b0, 8);

      run_div("13/0", 8'd13, 4'd0, 8'hFF, 4'd0, 1'b1, 1);
      tick();
      check("dz held in idle", div_by_zero, 1);
      check("dz done low", done, 0);
      run_div("100/9", 8'd100, 4'd9, 8'd11, 4'd1, 1'b0, 8);

      // Second request while busy must be ignored.
      start = 1'b1; dividend = 8'd150; divisor = 4'd4;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; dividend = 8'd99; divisor = 4'd3;
      tick();
      start = 1'b0;
      pulses = 0; lat = 99; q_at_done = '0; r_at_done = '0;
      for (int i = 4; i <= 16; i++) begin
         tick();
         if (done) begin
            pulses++;
            if (pulses == 1) begin
               lat = i; q_at_done = quotient; r_at_done = remainder;
            end
         end
      end
      check("busy-ignore pulses", pulses, 1);
      check("busy-ignore latency", lat, 8);
      check("busy-ignore quotient", q_at_done, 37);
      check("busy-ignore remainder", r_at_done, 2);

      // Reset mid-operation aborts without a done pulse.
      start = 1'b1; dividend = 8'd250; divisor = 4'd6;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      check("abort quotient", quotient, 0);
      check("abort remainder", remainder, 0);
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) pulses++;
      end
      check("abort no done", pulses, 0);
      run_div("250/6", 8'd250, 4'd6, 8'd41, 4'd4, 1'b0, 8);

      // start held across DONE gives a back-to-back accept.
      start = 1'b1; dividend = 8'd100; divisor = 4'd9;
      tick();
      dividend = 8'd77; divisor = 4'd5;
      wait_done(lat);
      check("b2b first latency", lat, 8);
      check("b2b first quotient", quotient, 11);
      check("b2b first remainder", remainder, 1);
      tick();
      start = 1'b0;
      check("b2b re-accept busy", busy, 1);
      check("b2b re-accept done low", done, 0);
      wait_done(lat);
      check("b2b gap", lat + 1, 9);
      check("b2b second quotient", quotient, 15);
      check("b2b second remainder", remainder, 2);

      for (int ds = 1; ds < 16; ds++) begin
         for (int dd = 0; dd < 256; dd++) begin
            start = 1'b1; dividend = 8'(dd); divisor = 4'(ds);
            tick();
            start = 1'b0;
            wait_done(lat);
            check("sweep quotient", quotient, 32'(dd / ds));
            check("sweep remainder", remainder, 32'(dd % ds));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
